cam_alloc_ctrl: RTL and testbench

Lookup/allocate controller that sits directly upstream of tri_port_regfile and drives its write and CAM ports. It takes one tag request at a time and searches the regfile by CAM. On a hit it returns the matching entry index. On a miss it allocates an entry (first free entry, otherwise a round-robin victim), writes the tag into that entry and returns the allocated index. The block owns the per-entry valid bits; regfile contents are never cleared.

---
 rtl/cam_alloc_ctrl_if.sv | 43 ++++
 rtl/cam_alloc_ctrl.sv | 130 +++++++++++++
 tb/tb_cam_alloc_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cam_alloc_ctrl_if.sv
// Request/response, invalidate and regfile CAM/write signals of cam_alloc_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface cam_alloc_ctrl_if #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUM_ENTRY                 = 4,
  parameter int NUM_ENTRY_LOG2            = 2
);
  logic                                 request_valid_in;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_tag_in;
  logic                                 request_ready_out;
  logic                                 response_valid_out;
  logic                                 response_ready_in;
  logic                                 response_hit_out;
  logic [NUM_ENTRY_LOG2-1:0]            response_index_out;
  logic                                 response_evict_out;
  logic                                 invalidate_en_in;
  logic [NUM_ENTRY-1:0]                 invalidate_mask_in;
  logic                                 cam_en_out;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] cam_entry_out;
  logic [NUM_ENTRY-1:0]                 cam_result_decoded_in;
  logic                                 write_en_out;
  logic [NUM_ENTRY-1:0]                 write_entry_addr_decoded_out;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_out;
  logic [NUM_ENTRY-1:0]                 valid_bits_out;

  modport slave (
    input  request_valid_in, request_tag_in, response_ready_in,
           invalidate_en_in, invalidate_mask_in, cam_result_decoded_in,
    output request_ready_out, response_valid_out, response_hit_out,
           response_index_out, response_evict_out, cam_en_out, cam_entry_out,
           write_en_out, write_entry_addr_decoded_out, write_entry_out,
           valid_bits_out
  );

  modport master (
    output request_valid_in, request_tag_in, response_ready_in,
           invalidate_en_in, invalidate_mask_in, cam_result_decoded_in,
    input  request_ready_out, response_valid_out, response_hit_out,
           response_index_out, response_evict_out, cam_en_out, cam_entry_out,
           write_en_out, write_entry_addr_decoded_out, write_entry_out,
           valid_bits_out
  );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Lookup/allocate controller in front of tri_port_regfile: CAM search, then
// hit index or allocation (first free entry, else round-robin victim).
module cam_alloc_ctrl #(
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 8,
  parameter int NUM_ENTRY                 = 4,
  parameter int NUM_ENTRY_LOG2            = 2
) (
  input logic             clk_in,
  input logic             reset_in,
  cam_alloc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WRITE, RESP} state_t;

  state_t                               state, state_next;
  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] tag_reg;
  logic [NUM_ENTRY-1:0]                 valid_bits;
  logic [NUM_ENTRY_LOG2-1:0]            rr_ptr;
  logic [NUM_ENTRY_LOG2-1:0]            index_reg;
  logic                                 hit_reg;
  logic                                 evict_reg;

  logic [NUM_ENTRY-1:0]      inv_mask, valid_after_inv, match, write_onehot;
  logic                      match_any, free_any;
  logic [NUM_ENTRY_LOG2-1:0] match_idx, free_idx;

  // Priority encoders: the downward loop leaves the lowest qualifying index.
  always_comb begin
    inv_mask        = bus.invalidate_en_in ? bus.invalidate_mask_in : '0;
    valid_after_inv = valid_bits & ~inv_mask;
    match           = bus.cam_result_decoded_in & valid_after_inv;
    match_any       = |match;
    free_any        = ~&valid_after_inv;
    write_onehot    = {{(NUM_ENTRY-1){1'b0}}, 1'b1} << index_reg;
    match_idx       = '0;
    free_idx        = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (match[i])           match_idx = NUM_ENTRY_LOG2'(i);
      if (!valid_after_inv[i]) free_idx = NUM_ENTRY_LOG2'(i);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output and state_next gets a default before the case, so no
  // path through this block can infer a latch.
  always_comb begin
    state_next                       = state;
    bus.request_ready_out            = 1'b0;
    bus.response_valid_out           = 1'b0;
    bus.response_hit_out             = 1'b0;
    bus.response_index_out           = '0;
    bus.response_evict_out           = 1'b0;
    bus.cam_en_out                   = 1'b0;
    bus.cam_entry_out                = '0;
    bus.write_en_out                 = 1'b0;
    bus.write_entry_addr_decoded_out = '0;
    bus.write_entry_out              = '0;
    unique case (state)
      IDLE: begin
        bus.request_ready_out = ~reset_in;
        if (bus.request_valid_in && !reset_in) state_next = LOOKUP;
      end
      LOOKUP: begin
        bus.cam_en_out    = 1'b1;
        bus.cam_entry_out = tag_reg;
        state_next        = COMPARE;
      end
      COMPARE: state_next = match_any ? RESP : WRITE;
      WRITE: begin
        bus.write_en_out                 = 1'b1;
        bus.write_entry_addr_decoded_out = write_onehot;
        bus.write_entry_out              = tag_reg;
        state_next                       = RESP;
      end
      RESP: begin
        bus.response_valid_out = 1'b1;
        bus.response_hit_out   = hit_reg;
        bus.response_index_out = index_reg;
        bus.response_evict_out = evict_reg;
        if (bus.response_ready_in) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only the valid bits and bookkeeping live here; regfile contents are
  // never cleared, so a reset simply forgets every entry.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      tag_reg    <= '0;
      valid_bits <= '0;
      rr_ptr     <= '0;
      index_reg  <= '0;
      hit_reg    <= 1'b0;
      evict_reg  <= 1'b0;
    end else begin
      // A WRITE set overrides a same-cycle invalidate of that entry.
      valid_bits <= valid_after_inv | ((state == WRITE) ? write_onehot : '0);

      if (state == IDLE && bus.request_valid_in) tag_reg <= bus.request_tag_in;

      if (state == COMPARE) begin
        hit_reg <= match_any;
        if (match_any) begin
          index_reg <= match_idx;
          evict_reg <= 1'b0;
        end else if (free_any) begin
          index_reg <= free_idx;
          evict_reg <= 1'b0;
        end else begin
          index_reg <= rr_ptr;
          evict_reg <= 1'b1;
        end
      end

      if (state == WRITE && evict_reg)
        rr_ptr <= (rr_ptr == NUM_ENTRY_LOG2'(NUM_ENTRY - 1)) ? '0
                                                             : rr_ptr + NUM_ENTRY_LOG2'(1);
    end
  end

  assign bus.valid_bits_out = valid_bits;

endmodule

// File: tb/tb_cam_alloc_ctrl.sv
// Directed bench for cam_alloc_ctrl; the bench drives the regfile CAM match
// vector directly with hand-computed values.
module tb_cam_alloc_ctrl;
  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 2;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  int   checks   = 0;
  int   errors   = 0;

  cam_alloc_ctrl_if #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_ENTRY(N), .NUM_ENTRY_LOG2(L)) bus ();

  cam_alloc_ctrl #(.SINGLE_ENTRY_SIZE_IN_BITS(W), .NUM_ENTRY(N), .NUM_ENTRY_LOG2(L)) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One request: inv_cycle (1 = LOOKUP, 2 = COMPARE, 3 = WRITE, 0 = none)
  // pulses invalidate with inv_mask; hold keeps response_ready low that long.
  task automatic do_req(input string name, input logic [W-1:0] tag,
                        input logic [N-1:0] cam, input logic exp_hit,
                        input logic [L-1:0] exp_idx, input logic exp_evict,
                        input int exp_lat, input int hold,
                        input int inv_cycle, input logic [N-1:0] inv_mask);
    int             lat;
    int             cam_cnt;
    int             wr_cnt;
    logic [W-1:0]   cam_key;
    logic [W-1:0]   wr_data;
    logic [N-1:0]   wr_addr;
    logic           hit_s;
    logic [L-1:0]   idx_s;
    logic           evict_s;
    cam_cnt = 0;
    wr_cnt  = 0;
    cam_key = '0;
    wr_data = '0;
    wr_addr = '0;
    check({name, "_ready_idle"}, 32'(bus.request_ready_out), 32'd1);
    bus.response_ready_in     = (hold == 0);
    bus.cam_result_decoded_in = cam;
    bus.request_tag_in        = tag;
    bus.request_valid_in      = 1'b1;
    tick();
    bus.request_valid_in = 1'b0;
    lat = 1;
    while (!bus.response_valid_out && lat < 12) begin
      if (bus.cam_en_out) begin
        cam_cnt++;
        cam_key = bus.cam_entry_out;
      end
      if (bus.write_en_out) begin
        wr_cnt++;
        wr_addr = bus.write_entry_addr_decoded_out;
        wr_data = bus.write_entry_out;
      end
      if (lat == inv_cycle) begin
        bus.invalidate_en_in   = 1'b1;
        bus.invalidate_mask_in = inv_mask;
      end
      tick();
      bus.invalidate_en_in   = 1'b0;
      bus.invalidate_mask_in = '0;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_hit"}, 32'(bus.response_hit_out), 32'(exp_hit));
    check({name, "_index"}, 32'(bus.response_index_out), 32'(exp_idx));
    check({name, "_evict"}, 32'(bus.response_evict_out), 32'(exp_evict));
    check({name, "_cam_pulses"}, 32'(cam_cnt), 32'd1);
    check({name, "_cam_key"}, 32'(cam_key), 32'(tag));
    check({name, "_write_pulses"}, 32'(wr_cnt), exp_hit ? 32'd0 : 32'd1);
    if (!exp_hit) begin
      check({name, "_write_addr"}, 32'(wr_addr), 32'(1 << exp_idx));
      check({name, "_write_data"}, 32'(wr_data), 32'(tag));
    end
    hit_s   = bus.response_hit_out;
    idx_s   = bus.response_index_out;
    evict_s = bus.response_evict_out;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_hold_valid"}, 32'(bus.response_valid_out), 32'd1);
      check({name, "_hold_fields"},
            32'({bus.response_hit_out, bus.response_index_out, bus.response_evict_out}),
            32'({hit_s, idx_s, evict_s}));
      check({name, "_hold_req_ready"}, 32'(bus.request_ready_out), 32'd0);
    end
    bus.response_ready_in = 1'b1;
    tick();
    check({name, "_resp_done"}, 32'(bus.response_valid_out), 32'd0);
    check({name, "_back_idle"}, 32'(bus.request_ready_out), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.request_valid_in      = 1'b0;
    bus.request_tag_in        = '0;
    bus.response_ready_in     = 1'b1;
    bus.invalidate_en_in      = 1'b0;
    bus.invalidate_mask_in    = '0;
    bus.cam_result_decoded_in = '0;

    // Reset state
    repeat (2) tick();
    check("rst_req_ready", 32'(bus.request_ready_out), 32'd0);
    check("rst_valid_bits", 32'(bus.valid_bits_out), 32'd0);
    check("rst_outputs",
          32'({bus.response_valid_out, bus.cam_en_out, bus.write_en_out,
               bus.write_entry_addr_decoded_out}), 32'd0);
    reset_in = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus.request_ready_out), 32'd1);

    // First allocation into an empty table, then a hit on it
    do_req("alloc_f0", 8'hF0, 4'b0000, 1'b0, 2'd0, 1'b0, 4, 0, 0, 4'b0000);
    check("valid_after_f0", 32'(bus.valid_bits_out), 32'b0001);
    do_req("hit_f0", 8'hF0, 4'b0001, 1'b1, 2'd0, 1'b0, 3, 0, 0, 4'b0000);

    // Fill, then round-robin eviction
    do_req("alloc_01", 8'h01, 4'b0000, 1'b0, 2'd1, 1'b0, 4, 0, 0, 4'b0000);
    do_req("alloc_02", 8'h02, 4'b0000, 1'b0, 2'd2, 1'b0, 4, 0, 0, 4'b0000);
    do_req("alloc_03", 8'h03, 4'b0000, 1'b0, 2'd3, 1'b0, 4, 0, 0, 4'b0000);
    check("valid_full", 32'(bus.valid_bits_out), 32'b1111);
    do_req("evict_0f", 8'h0F, 4'b0000, 1'b0, 2'd0, 1'b1, 4, 0, 0, 4'b0000);
    do_req("evict_10", 8'h10, 4'b0000, 1'b0, 2'd1, 1'b1, 4, 0, 0, 4'b0000);

    // Invalidate opens a hole; free allocation must not move the pointer
    bus.invalidate_en_in   = 1'b1;
    bus.invalidate_mask_in = 4'b0100;
    tick();
    bus.invalidate_en_in   = 1'b0;
    bus.invalidate_mask_in = '0;
    check("valid_after_inv", 32'(bus.valid_bits_out), 32'b1011);
    do_req("refill_20", 8'h20, 4'b0000, 1'b0, 2'd2, 1'b0, 4, 0, 0, 4'b0000);
    do_req("evict_30", 8'h30, 4'b0000, 1'b0, 2'd2, 1'b1, 4, 0, 0, 4'b0000);

    // Multi-hit resolves low; invalidate during COMPARE masks the match
    do_req("multi_hit", 8'h02, 4'b1010, 1'b1, 2'd1, 1'b0, 3, 0, 0, 4'b0000);
    do_req("hit_inv_cmp", 8'h02, 4'b1010, 1'b1, 2'd3, 1'b0, 3, 0, 2, 4'b0010);
    check("valid_after_cmp_inv", 32'(bus.valid_bits_out), 32'b1101);

    // Back-pressure on the response
    do_req("hold_40", 8'h40, 4'b0000, 1'b0, 2'd1, 1'b0, 4, 5, 0, 4'b0000);
    check("valid_after_hold", 32'(bus.valid_bits_out), 32'b1111);

    // Reset asserted in WRITE drops the request
    bus.cam_result_decoded_in = 4'b0000;
    bus.request_tag_in        = 8'h50;
    bus.request_valid_in      = 1'b1;
    tick();
    bus.request_valid_in = 1'b0;
    tick();
    tick();
    check("mid_write_en", 32'(bus.write_en_out), 32'd1);
    reset_in = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.valid_bits_out), 32'd0);
    check("mid_rst_write_en", 32'(bus.write_en_out), 32'd0);
    check("mid_rst_req_ready", 32'(bus.request_ready_out), 32'd0);
    tick();
    reset_in = 1'b0;
    #1;
    check("mid_rst_idle", 32'(bus.request_ready_out), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_resp", 32'(bus.response_valid_out), 32'd0);
    end

    // Same-cycle invalidate and WRITE of one entry: the set wins
    do_req("set_wins", 8'h60, 4'b0000, 1'b0, 2'd0, 1'b0, 4, 0, 3, 4'b0001);
    check("valid_set_wins", 32'(bus.valid_bits_out), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
